// File: rtl/max7219_receiver_if.sv
// max7219_receiver_if: serial pins, frame status and register outputs of the MAX7219-style receiver
interface max7219_receiver_if;
  logic       i_serial_clk;
  logic       i_serial_din;
  logic       i_serial_load;
  logic       o_serial_dout;
  logic       o_frame_stb;
  logic       o_frame_err;
  logic [3:0] o_addr;
  logic [7:0] o_data;
  logic [2:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic [7:0] o_decode_mode;
  logic [3:0] o_intensity;
  logic [2:0] o_scan_limit;
  logic       o_shutdown;
  logic       o_test;
  modport slave (
    input  i_serial_clk, i_serial_din, i_serial_load, i_rd_addr,
    output o_serial_dout, o_frame_stb, o_frame_err, o_addr, o_data, o_rd_data,
           o_decode_mode, o_intensity, o_scan_limit, o_shutdown, o_test
  );
  modport master (
    output i_serial_clk, i_serial_din, i_serial_load, i_rd_addr,
    input  o_serial_dout, o_frame_stb, o_frame_err, o_addr, o_data, o_rd_data,
           o_decode_mode, o_intensity, o_scan_limit, o_shutdown, o_test
  );
endinterface

// File: rtl/max7219_receiver.sv
// max7219_receiver: oversampling MAX7219-compatible serial receiver with frame decode and register file
module max7219_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input logic              i_clk,
  input logic              i_reset,
  max7219_receiver_if.slave bus
);
  logic [SYNC_STAGES-1:0] sclk_sync_q, din_sync_q, load_sync_q;
  logic                   sclk_prev_q, load_prev_q;
  logic [2:0]             arm_q;
  logic                   armed, sclk_rise, load_rise, commit;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   dout_q, stb_q, err_q;
  logic [3:0]             addr_q, intensity_q, wr_addr;
  logic [7:0]             data_q, decode_q, wr_data;
  logic [2:0]             scan_q;
  logic                   shutdown_q, test_q;
  logic [7:0]             digit_q [8];

  // synchronize the serial pins, keep one delayed copy for edge detection, and hold off edges until the chains have refilled
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      load_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      load_prev_q <= 1'b0;
      arm_q       <= 3'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_serial_clk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.i_serial_din};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], bus.i_serial_load};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      load_prev_q <= load_sync_q[SYNC_STAGES-1];
      arm_q       <= armed ? arm_q : arm_q + 3'd1;
    end

  // edge detection, shift and bit-count next state; a load edge clears the count before a coincident shift is counted
  always_comb begin
    armed     = arm_q == 3'(SYNC_STAGES + 1);
    sclk_rise = armed & sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    load_rise = armed & load_sync_q[SYNC_STAGES-1] & ~load_prev_q;
    commit    = load_rise & cnt_q[4];
    wr_addr   = shift_q[11:8];
    wr_data   = shift_q[7:0];
    shift_d   = sclk_rise ? {shift_q[14:0], din_sync_q[SYNC_STAGES-1]} : shift_q;
    cnt_d     = load_rise ? {4'd0, sclk_rise}
              : (sclk_rise && cnt_q != 5'd31) ? cnt_q + 5'd1 : cnt_q;
  end

  // shift register, daisy-chain output, bit counter and frame status pulses
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stb_q   <= commit;
      err_q   <= load_rise & ~cnt_q[4];
      if (sclk_rise) dout_q <= shift_q[15];
      if (commit) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
      end
    end

  // register file written by committed frames; the display powers up in shutdown
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      shutdown_q  <= 1'b1;
      test_q      <= 1'b0;
    end else if (commit) begin
      if (wr_addr inside {[4'h1:4'h8]}) digit_q[3'(wr_addr - 4'd1)] <= wr_data;
      if (wr_addr == 4'h9) decode_q <= wr_data;
      if (wr_addr == 4'hA) intensity_q <= wr_data[3:0];
      if (wr_addr == 4'hB) scan_q <= wr_data[2:0];
      if (wr_addr == 4'hC) shutdown_q <= ~wr_data[0];
      if (wr_addr == 4'hF) test_q <= wr_data[0];
    end

  assign bus.o_serial_dout = dout_q;
  assign bus.o_frame_stb   = stb_q;
  assign bus.o_frame_err   = err_q;
  assign bus.o_addr        = addr_q;
  assign bus.o_data        = data_q;
  assign bus.o_rd_data     = digit_q[bus.i_rd_addr];
  assign bus.o_decode_mode = decode_q;
  assign bus.o_intensity   = intensity_q;
  assign bus.o_scan_limit  = scan_q;
  assign bus.o_shutdown    = shutdown_q;
  assign bus.o_test        = test_q;
endmodule

// File: tb/tb_max7219_receiver.sv
// tb_max7219_receiver: randomized serial frames checked against a bit-history model of the receiver
module tb_max7219_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max7219_receiver_if bus();
  max7219_receiver #(.SYNC_STAGES(2)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int checks = 0, failures = 0, stb_cnt = 0, err_cnt = 0;
  logic [11:0] snap_ad;
  logic [16:0] snap_cfg;
  bit hist[$];
  int m_cnt;
  logic [7:0] m_digit [8];
  logic [7:0] m_decode, m_data;
  logic [3:0] m_int, m_addr;
  logic [2:0] m_scan;
  logic m_shdn, m_test, exp_dout;
  bit m_commit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] m_cfg();
    return {m_decode, m_int, m_scan, m_shdn, m_test};
  endfunction

  function automatic logic [16:0] dut_cfg();
    return {bus.o_decode_mode, bus.o_intensity, bus.o_scan_limit, bus.o_shutdown, bus.o_test};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 8'h00; m_data = 8'h00; m_int = 4'h0; m_addr = 4'h0;
    m_scan = 3'd0; m_shdn = 1'b1; m_test = 1'b0; exp_dout = 1'b0;
  endtask

  task automatic model_bit(input bit b);
    hist.push_back(b);
    m_cnt++;
    exp_dout = hist.size() > 16 ? hist[hist.size() - 17] : 1'b0;
  endtask

  task automatic model_load();
    logic [15:0] w;
    w = 16'h0000;
    m_commit = m_cnt >= 16;
    if (m_commit) begin
      for (int k = 0; k < 16; k++) w = {w[14:0], hist[hist.size() - 16 + k]};
      m_addr = w[11:8];
      m_data = w[7:0];
      case (w[11:8])
        4'h9: m_decode = w[7:0];
        4'hA: m_int = w[3:0];
        4'hB: m_scan = w[2:0];
        4'hC: m_shdn = ~w[0];
        4'hF: m_test = w[0];
        4'h0, 4'hD, 4'hE: ;
        default: m_digit[int'(w[11:8]) - 1] = w[7:0];
      endcase
    end
    m_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (bus.o_frame_stb) begin
      stb_cnt++;
      snap_ad = {bus.o_addr, bus.o_data};
      snap_cfg = dut_cfg();
    end
    if (bus.o_frame_err) err_cnt++;
    if (bus.o_frame_stb | bus.o_frame_err) chk("stb_err_excl", 32'(bus.o_frame_stb & bus.o_frame_err), 0);
  end

  task automatic load_checks(input int s0, input int e0);
    chk("stb_count", stb_cnt - s0, 32'(m_commit));
    chk("err_count", err_cnt - e0, 32'(!m_commit));
    if (m_commit) begin
      chk("snap_addr_data", snap_ad, {m_addr, m_data});
      chk("snap_cfg", snap_cfg, m_cfg());
    end
    chk("addr_data", {bus.o_addr, bus.o_data}, {m_addr, m_data});
    chk("cfg", dut_cfg(), m_cfg());
  endtask

  task automatic send_bit(input bit b, input bit ld);
    int s0, e0;
    logic p;
    @(negedge clk);
    bus.i_serial_din = b;
    bus.i_serial_clk = 1'b0;
    repeat (3) @(negedge clk);
    s0 = stb_cnt; e0 = err_cnt; p = exp_dout;
    if (ld) begin
      model_load();
      bus.i_serial_load = 1'b1;
    end
    model_bit(b);
    bus.i_serial_clk = 1'b1;
    repeat (2) @(negedge clk);
    chk("dout_hold", bus.o_serial_dout, p);
    @(negedge clk);
    chk("dout", bus.o_serial_dout, exp_dout);
    repeat (2) @(negedge clk);
    if (ld) begin
      bus.i_serial_load = 1'b0;
      repeat (3) @(negedge clk);
      load_checks(s0, e0);
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic do_load();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    model_load();
    @(negedge clk);
    bus.i_serial_load = 1'b1;
    repeat (6) @(negedge clk);
    bus.i_serial_load = 1'b0;
    repeat (3) @(negedge clk);
    load_checks(s0, e0);
  endtask

  task automatic check_digits();
    for (int i = 0; i < 8; i++) begin
      bus.i_rd_addr = 3'(i);
      #1 chk("digit", bus.o_rd_data, m_digit[i]);
    end
  endtask

  task automatic reset_check();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_cfg", dut_cfg(), m_cfg());
    chk("rst_addr_data", {bus.o_addr, bus.o_data}, 0);
    chk("rst_pulses_dout", {bus.o_frame_stb, bus.o_frame_err, bus.o_serial_dout}, 0);
    check_digits();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int r, n;
    bus.i_serial_clk = 1'b0;
    bus.i_serial_din = 1'b0;
    bus.i_serial_load = 1'b0;
    bus.i_rd_addr = 3'd0;
    reset_check();
    send_bits(32'h0A05, 16); do_load();
    chk("intensity_5", 32'(bus.o_intensity), 5);
    send_bits(32'h0C01, 16); do_load();
    send_bits(32'h0C00, 16); do_load();
    send_bits({16'h03AA, 16'h0155}, 32); do_load();
    check_digits();
    send_bits(32'h03FF, 10); do_load();
    send_bits(32'h0811, 16); do_load();
    check_digits();
    send_bits(32'h0012, 16); do_load();
    send_bits(32'h0D34, 16); do_load();
    send_bits(32'h0E56, 16); do_load();
    send_bits(32'h0B05, 16);
    w = 32'h0903;
    send_bit(w[15], 1'b1);
    send_bits(w, 15); do_load();
    for (int t = 0; t < 24; t++) begin
      w = $urandom;
      r = $urandom_range(0, 7);
      n = r == 0 ? $urandom_range(1, 15) : r == 1 ? 32 : 16;
      if (r == 2) begin
        send_bits(w, 16);
        send_bit(w[16], 1'b1);
        send_bits(w, 15);
      end else send_bits(w, n);
      do_load();
    end
    check_digits();
    send_bits(32'h0B, 8);
    reset_check();
    send_bits(32'hFF, 8); do_load();
    check_digits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
